mult_div_seq: RTL and testbench
===============================

# mult_div_seq

Iterative signed multiply/divide sequencer that owns the HI/LO register pair of the multicycle CPU. Control issues a one-cycle start pulse with operands from the A/B registers. The block runs a 32-step shift-add (Booth radix-2) or restoring-divide sequence on a single shared 33-bit adder, then pulses done. Control holds its state machine in a wait state until done or div_zero, then proceeds to mfhi/mflo or the exception path.

## Interface
- No parameters; datapath width fixed at 32 bits, iteration count fixed at 32.
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start_mult  input  1  one-cycle request: signed multiply op_a * op_b
- start_div  input  1  one-cycle request: signed divide op_a / op_b
- op_a  input  32  operand A (multiplicand / dividend), sampled only on accepted start
- op_b  input  32  operand B (multiplier / divisor), sampled only on accepted start
- busy  output  1  high while an operation is in progress (ITER state)
- done  output  1  one-cycle pulse; HI/LO hold the new result in the same cycle
- div_zero  output  1  one-cycle pulse; divide requested with op_b = 0
- hi  output  32  HI register (mult: product[63:32]; div: remainder)
- lo  output  32  LO register (mult: product[31:0]; div: quotient)

## Operation
- States: IDLE, ITER, FINISH, DZERO.
- IDLE: a start is accepted only here. start_mult wins if both starts are high; start_div is dropped, no error.
- Start accepted in IDLE, start_div with op_b = 0: go to DZERO. No iteration; HI/LO unchanged.
- Start accepted in IDLE, all other cases:
  - Latch operands into internal registers.
  - Clear the 5-bit step counter.
  - Record the op type and operand signs.
  - Go to ITER.
- ITER, multiply (Booth radix-2):
  - Accumulator {P[63:0], q-1}.
  - Each step: add +A, -A or 0 per bits {P[0], q-1}, then arithmetic shift right by 1.
  - The 33-bit add avoids overflow at A = 0x80000000.
- ITER, divide (restoring, on magnitudes |A| and |B| as 32-bit unsigned):
  - Each step: shift remainder:quotient left by 1 and trial-subtract |B|.
  - On no borrow, keep the difference and set quotient bit 0 to 1.
- ITER exit: after step counter = 31 completes, go to FINISH and write HI/LO at that edge.
- Divide result sign fix, applied combinationally at the HI/LO write:
  - Quotient negated if sign(A) != sign(B); truncation toward zero.
  - Remainder negated if A is negative; remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF: defined result lo = 0x80000000, hi = 0x00000000. No exception.
- FINISH: done = 1 for one cycle, then IDLE.
- DZERO: div_zero = 1 for one cycle, done stays 0, then IDLE.
- Starts asserted in ITER, FINISH or DZERO are ignored. Control must not issue them.
- Changes on op_a/op_b after acceptance have no effect on the result.

## Timing
- Reset values: busy = 0, done = 0, div_zero = 0, hi = 0x00000000, lo = 0x00000000, state = IDLE, counter = 0.
- Reset asserted in any state, including mid-ITER: IDLE next edge, partial result discarded, HI/LO cleared, no done pulse.
- Start sampled at the edge ending cycle 0.
- busy is high in cycles 1..32.
- HI/LO update at the edge ending cycle 32.
- done is high in cycle 33; the block is back in IDLE in cycle 34.
- Minimum spacing between accepted starts is 34 cycles.
- A start presented in cycle 33 (FINISH) is ignored.
- A start presented in cycle 34 is accepted.
- Divide by zero: div_zero high in cycle 1; IDLE in cycle 2; busy never asserts.
- hi/lo are driven directly from registers, with no combinational path from inputs.
- hi/lo change only on a completed op or on reset.

## Test plan
- Mult 7 * -3 (op_a = 0x00000007, op_b = 0xFFFFFFFD):
  - busy cycles 1-32, done in cycle 33.
  - hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- Mult corner 0x80000000 * 0x80000000: hi = 0x40000000, lo = 0x00000000.
- Div -7 / 2 (op_a = 0xFFFFFFF9, op_b = 0x00000002): done in cycle 33, lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- Div 100 / 0:
  - div_zero pulses in cycle 1, done never asserts, busy stays 0.
  - Prior HI/LO values (e.g. 0x12345678 / 0x9ABCDEF0 from an earlier mult) are retained.
- Div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000, no div_zero.
- Arbitration, ignored starts and reset:
  - start_mult and start_div together with 6, 3: product hi = 0x00000000, lo = 0x00000012.
  - A start pulsed in cycle 10 of that op is ignored.
  - A separate op reset at cycle 15: cycle 16 shows busy = 0 and hi = lo = 0, and no done pulse ever appears.

Source files
------------

// File: rtl/mult_div_seq_if.sv
// Bundle between the CPU control FSM and the HI/LO multiply/divide sequencer.
// Ports: start_mult/start_div/op_a/op_b driven by control (master);
//        busy/done/div_zero/hi/lo driven by the sequencer (slave).
interface mult_div_seq_if;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start_mult, start_div, op_a, op_b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start_mult, start_div, op_a, op_b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_seq.sv
// Iterative signed multiply (Booth radix-2) / restoring divide owning HI/LO.
// Latency: start -> 32 busy cycles -> done pulse; divide-by-zero flags in 1 cycle.
// Backpressure: none; starts are only accepted in IDLE, all others are dropped.
// Ports: clk, reset (sync, active-high), bus (slave side of mult_div_seq_if).
module mult_div_seq (
    input  logic           clk,
    input  logic           reset,
    mult_div_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ITER, FINISH, DZERO} state_t;

    state_t      state;
    logic [4:0]  step;
    logic        op_div;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] operand;    // mult: multiplicand A; div: divisor magnitude |B|
    logic [63:0] acc;        // mult: product P; div: {remainder, quotient}
    logic        qm1;        // Booth q-1 bit
    logic        busy_q;
    logic        done_q;
    logic        dz_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] add_x;
    logic [32:0] add_y;
    logic        add_cin;
    logic [32:0] add_sum;
    logic [63:0] acc_nxt;
    logic        qm1_nxt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign abs_a = bus.op_a[31] ? (32'd0 - bus.op_a) : bus.op_a;
    assign abs_b = bus.op_b[31] ? (32'd0 - bus.op_b) : bus.op_b;

    // Single shared 33-bit adder. Subtraction is done as x + ~y + 1.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        if (op_div) begin
            // Shifted remainder {rem, next quotient bit} minus {0, |B|}.
            // Since rem < |B|, bit 32 of the result is exactly the borrow.
            add_x   = {acc[63:32], acc[31]};
            add_y   = ~{1'b0, operand};
            add_cin = 1'b1;
        end else begin
            // Sign-extended upper half so A = 0x80000000 cannot overflow.
            add_x = {acc[63], acc[63:32]};
            case ({acc[0], qm1})
                2'b01: add_y = {operand[31], operand};
                2'b10: begin
                    add_y   = ~{operand[31], operand};
                    add_cin = 1'b1;
                end
                default: add_y = '0;
            endcase
        end
    end

    assign add_sum = add_x + add_y + {32'd0, add_cin};

    always_comb begin
        acc_nxt = acc;
        qm1_nxt = qm1;
        if (op_div) begin
            if (!add_sum[32])
                acc_nxt = {add_sum[31:0], acc[30:0], 1'b1};
            else
                acc_nxt = {acc[62:0], 1'b0};
        end else begin
            // Arithmetic shift right of {sum, P[31:0]}; bit 32 of sum is the sign.
            acc_nxt = {add_sum, acc[31:1]};
            qm1_nxt = acc[0];
        end
    end

    // Divide sign fix-up: quotient truncates toward zero, remainder follows dividend.
    always_comb begin
        res_hi = acc_nxt[63:32];
        res_lo = acc_nxt[31:0];
        if (op_div) begin
            res_hi = neg_a ? (32'd0 - acc_nxt[63:32]) : acc_nxt[63:32];
            res_lo = (neg_a ^ neg_b) ? (32'd0 - acc_nxt[31:0]) : acc_nxt[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            step    <= '0;
            op_div  <= 1'b0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            operand <= '0;
            acc     <= '0;
            qm1     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_mult) begin
                        op_div  <= 1'b0;
                        neg_a   <= bus.op_a[31];
                        neg_b   <= bus.op_b[31];
                        operand <= bus.op_a;
                        acc     <= {32'd0, bus.op_b};
                        qm1     <= 1'b0;
                        step    <= '0;
                        busy_q  <= 1'b1;
                        state   <= ITER;
                    end else if (bus.start_div) begin
                        if (bus.op_b == 32'd0) begin
                            dz_q  <= 1'b1;
                            state <= DZERO;
                        end else begin
                            op_div  <= 1'b1;
                            neg_a   <= bus.op_a[31];
                            neg_b   <= bus.op_b[31];
                            operand <= abs_b;
                            acc     <= {32'd0, abs_a};
                            qm1     <= 1'b0;
                            step    <= '0;
                            busy_q  <= 1'b1;
                            state   <= ITER;
                        end
                    end
                end
                ITER: begin
                    acc  <= acc_nxt;
                    qm1  <= qm1_nxt;
                    step <= step + 5'd1;
                    if (step == 5'd31) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        state  <= FINISH;
                    end
                end
                FINISH:  state <= IDLE;
                DZERO:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_seq.sv
// Bench for mult_div_seq: cycle-level reference model plus directed vectors.
// Latency: model tracks 32 busy cycles, done in cycle 33, div_zero in cycle 1.
// Backpressure: none; stimulus also pulses starts the block must ignore.
module tb_mult_div_seq;
    logic clk = 1'b0;
    logic reset;

    mult_div_seq_if bus ();

    mult_div_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference model: counts down the busy window and computes results
    // with plain signed arithmetic at the moment a start is accepted.
    bit          m_valid = 1'b0;
    logic        m_busy, m_done, m_dz;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;
    longint      pr;
    int          sa, sb, q, r;
    bit          blocked;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_dz    = 1'b0;
            m_hi    = '0;
            m_lo    = '0;
            m_left  = 0;
        end else if (m_valid) begin
            blocked = m_done || m_dz || (m_left > 0);
            m_done  = 1'b0;
            m_dz    = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                end
            end else if (!blocked) begin
                if (bus.start_mult) begin
                    pr     = longint'($signed(bus.op_a)) * longint'($signed(bus.op_b));
                    p_hi   = pr[63:32];
                    p_lo   = pr[31:0];
                    m_left = 32;
                end else if (bus.start_div) begin
                    sa = bus.op_a;
                    sb = bus.op_b;
                    if (sb == 0) begin
                        m_dz = 1'b1;
                    end else begin
                        if (sa == 32'h8000_0000 && sb == -1) begin
                            q = sa;
                            r = 0;
                        end else begin
                            q = sa / sb;
                            r = sa % sb;
                        end
                        p_hi   = r;
                        p_lo   = q;
                        m_left = 32;
                    end
                end
            end
            m_busy = (m_left > 0);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk1("model_busy", bus.busy, m_busy);
            chk1("model_done", bus.done, m_done);
            chk1("model_div_zero", bus.div_zero, m_dz);
            chk("model_hi", bus.hi, m_hi);
            chk("model_lo", bus.lo, m_lo);
        end
    end

    // Issue one op at cycle 0; inj (if nonzero) pulses both starts at that cycle.
    task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input int inj, input logic [31:0] ehi, input logic [31:0] elo,
                         input bit edz);
        @(negedge clk);
        bus.start_mult = m;
        bus.start_div  = d;
        bus.op_a       = a;
        bus.op_b       = b;
        if (edz) begin
            @(negedge clk);
            bus.start_mult = 1'b0;
            bus.start_div  = 1'b0;
            bus.op_a       = $urandom;
            bus.op_b       = $urandom;
            chk1("dz_pulse_c1", bus.div_zero, 1'b1);
            chk1("dz_busy_c1", bus.busy, 1'b0);
            @(negedge clk);
            chk1("dz_clear_c2", bus.div_zero, 1'b0);
            chk1("dz_no_done_c2", bus.done, 1'b0);
            chk("dz_hi_kept", bus.hi, ehi);
            chk("dz_lo_kept", bus.lo, elo);
        end else begin
            for (int k = 1; k <= 33; k++) begin
                @(negedge clk);
                if (k == inj) begin
                    bus.start_mult = 1'b1;
                    bus.start_div  = 1'b1;
                    bus.op_a       = 32'h0000_0063;
                    bus.op_b       = 32'h0000_0005;
                end else begin
                    bus.start_mult = 1'b0;
                    bus.start_div  = 1'b0;
                    bus.op_a       = $urandom;
                    bus.op_b       = $urandom;
                end
                if (k == 1)  chk1("busy_c1", bus.busy, 1'b1);
                if (k == 32) begin
                    chk1("busy_c32", bus.busy, 1'b1);
                    chk1("done_c32", bus.done, 1'b0);
                end
                if (k == 33) begin
                    chk1("done_c33", bus.done, 1'b1);
                    chk1("busy_c33", bus.busy, 1'b0);
                    chk("result_hi", bus.hi, ehi);
                    chk("result_lo", bus.lo, elo);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int ndone;

    initial begin
        reset          = 1'b1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_hi", bus.hi, 32'h0);
        chk("reset_lo", bus.lo, 32'h0);
        chk1("reset_busy", bus.busy, 1'b0);
        chk1("reset_done", bus.done, 1'b0);

        do_op(1, 0, 32'h0000_0007, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        do_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 32'h0000_0000, 0);
        do_op(0, 1, 32'hFFFF_FFF9, 32'h0000_0002, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        do_op(0, 1, 32'h0000_0064, 32'h0000_0000, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1);
        do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'h8000_0000, 0);
        // Both starts: multiply wins; a start in cycle 10 is ignored.
        do_op(1, 1, 32'h0000_0006, 32'h0000_0003, 10, 32'h0000_0000, 32'h0000_0012, 0);
        // Start in cycle 33 ignored, the next one in cycle 34 is accepted.
        do_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h0000_0001, 0);
        do_op(0, 1, 32'h0000_0007, 32'hFFFF_FFFE, 0, 32'h0000_0001, 32'hFFFF_FFFD, 0);
        do_op(0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFE, 32'h0000_0002, 0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.start_mult = 1'b1;
        bus.op_a       = 32'd5;
        bus.op_b       = 32'd5;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            bus.start_mult = 1'b0;
            if (k == 15) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        chk1("rst_mid_busy", bus.busy, 1'b0);
        chk("rst_mid_hi", bus.hi, 32'h0);
        chk("rst_mid_lo", bus.lo, 32'h0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("rst_no_done", ndone, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
